// File: rtl/cpu_types_pkg.sv
// Purpose: shared types for the pipeline hazard controller.
//   REG_W       register-specifier width
//   CNT_W       performance counter width (used when HAZARD_PERF_EN is defined)
//   regbits_t   register specifier
//   hazard_state_t  controller FSM state
//   latch_ctrl_t    PC / pipeline latch enable and flush bundle
package cpu_types_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        DWAIT     = 2'd2,
        HALT      = 2'd3
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } latch_ctrl_t;

    localparam latch_ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    localparam latch_ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Purpose: pipeline <-> hazard controller signal bundle.
//   master: pipeline side (drives stage status, receives enables/flushes)
//   slave : hazard controller side
// Optional perf counters (stall_cycles, flush_events) exist only with HAZARD_PERF_EN.
interface hazard_control_unit_if;
    import cpu_types_pkg::*;

    regbits_t id_rs;
    regbits_t id_rt;
    logic     id_uses_rt;
    logic     ex_memREN;
    regbits_t ex_dest;
    logic     mem_dmemREN;
    logic     mem_dmemWEN;
    logic     dhit;
    logic     ihit;
    logic     mem_redirect;
    logic     mem_halt;

    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     halted;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memREN, ex_dest, mem_dmemREN, mem_dmemWEN,
               dhit, ihit, mem_redirect, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
`ifdef HAZARD_PERF_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memREN, ex_dest, mem_dmemREN, mem_dmemWEN,
               dhit, ihit, mem_redirect, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
`ifdef HAZARD_PERF_EN
        , output stall_cycles, flush_events
`endif
    );

endinterface

// File: rtl/load_use_detect.sv
// Purpose: combinational load-use comparator (load in EX feeding a source of ID).
//   i_id_rs, i_id_rt, i_id_uses_rt : ID source specifiers
//   i_ex_memREN, i_ex_dest         : EX load flag and destination
//   o_lu_hazard_c                  : stall required
module load_use_detect
    import cpu_types_pkg::*;
(
    input  regbits_t i_id_rs,
    input  regbits_t i_id_rt,
    input  logic     i_id_uses_rt,
    input  logic     i_ex_memREN,
    input  regbits_t i_ex_dest,
    output logic     o_lu_hazard_c
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_dest == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_dest == i_id_rt);

    // $zero is never a real producer.
    assign o_lu_hazard_c = i_ex_memREN && (i_ex_dest != '0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_control_unit.sv
// Purpose: stall/flush controller for the 5-stage pipeline.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : hazard_control_unit_if.slave (stage status in, PC/latch enable+flush out, halted)
// Optional feature macro HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module hazard_control_unit
    import cpu_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    hazard_control_unit_if.slave  bus
);

    hazard_state_t r_state;
    hazard_state_t w_next;
    logic          r_halted;
    latch_ctrl_t   w_ctrl;
    logic          w_lu_hazard;
    logic          w_dmem_req;
`ifdef HAZARD_PERF_EN
    logic             w_redirect_fire;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;
`endif

    load_use_detect u_load_use_detect (
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_ex_memREN   (bus.ex_memREN),
        .i_ex_dest     (bus.ex_dest),
        .o_lu_hazard_c (w_lu_hazard)
    );

    assign w_dmem_req = bus.mem_dmemREN || bus.mem_dmemWEN;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALT);
        end
    end

    // Next state and enables; the first matching rule wins.
    always_comb begin
        w_next = RUN;
        w_ctrl = CTRL_RUN;
`ifdef HAZARD_PERF_EN
        w_redirect_fire = 1'b0;
`endif
        if (RST) begin
            w_ctrl = CTRL_FREEZE;
        end else if (r_state == HALT) begin
            w_ctrl = CTRL_FREEZE;
            w_next = HALT;
        end else if ((r_state == DWAIT) && !bus.dhit) begin
            w_ctrl = CTRL_FREEZE;
            w_next = DWAIT;
        end else if (bus.mem_halt) begin
            w_ctrl = CTRL_FREEZE;
            w_next = HALT;
        end else if ((r_state != DWAIT) && w_dmem_req && !bus.dhit) begin
            // The DWAIT release cycle skips this rule: its dhit already arrived.
            w_ctrl = CTRL_FREEZE;
            w_next = DWAIT;
        end else if (bus.mem_redirect) begin
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
            w_ctrl.exmem_flush = 1'b1;
`ifdef HAZARD_PERF_EN
            w_redirect_fire    = 1'b1;
`endif
        end else if (w_lu_hazard && (r_state != LU_BUBBLE)) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX.
            w_ctrl.pc_en      = 1'b0;
            w_ctrl.ifid_en    = 1'b0;
            w_ctrl.idex_flush = 1'b1;
            w_next            = LU_BUBBLE;
        end else if (!bus.ihit) begin
            w_ctrl.pc_en      = 1'b0;
            w_ctrl.ifid_flush = 1'b1;
        end
    end

    assign bus.pc_en       = w_ctrl.pc_en;
    assign bus.ifid_en     = w_ctrl.ifid_en;
    assign bus.idex_en     = w_ctrl.idex_en;
    assign bus.exmem_en    = w_ctrl.exmem_en;
    assign bus.memwb_en    = w_ctrl.memwb_en;
    assign bus.ifid_flush  = w_ctrl.ifid_flush;
    assign bus.idex_flush  = w_ctrl.idex_flush;
    assign bus.exmem_flush = w_ctrl.exmem_flush;
    assign bus.halted      = r_halted && !RST;

`ifdef HAZARD_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!w_ctrl.pc_en && (r_state != HALT)) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
            if (w_redirect_fire) begin
                r_flush_events <= sat_inc(r_flush_events);
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Purpose: self-checking bench for hazard_control_unit. Each step drives one cycle of
// pipeline status, queues the expected enable/flush/halted vector, and compares it on
// the following falling edge. HAZARD_PERF_EN additionally checks the perf counters.
module tb_hazard_control_unit;
    import cpu_types_pkg::*;

    // Expected vector order: {pc, ifid_en, idex_en, exmem_en, memwb_en,
    //                         ifid_fl, idex_fl, exmem_fl, halted}
    localparam logic [8:0] E_BASE   = 9'b1_1111_000_0;
    localparam logic [8:0] E_OFF    = 9'b0_0000_000_0;
    localparam logic [8:0] E_LU     = 9'b0_0111_010_0;
    localparam logic [8:0] E_REDIR  = 9'b1_1111_111_0;
    localparam logic [8:0] E_IMISS  = 9'b0_1111_100_0;
    localparam logic [8:0] E_HALTED = 9'b0_0000_000_1;

    typedef struct {
        regbits_t   rs;
        regbits_t   rt;
        logic       uses_rt;
        logic       ex_ren;
        regbits_t   ex_dest;
        logic       dren;
        logic       dwen;
        logic       dhit;
        logic       ihit;
        logic       redir;
        logic       halt;
        logic       rst;
        logic [8:0] exp;
        logic       chk;
        int         es;
        int         ef;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_control_unit_if bus ();

    hazard_control_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    function automatic step_t idle(input logic [8:0] e);
        step_t s;
        s.rs = 5'd1; s.rt = 5'd2; s.uses_rt = 1'b0; s.ex_ren = 1'b0; s.ex_dest = 5'd3;
        s.dren = 1'b0; s.dwen = 1'b0; s.dhit = 1'b0; s.ihit = 1'b1;
        s.redir = 1'b0; s.halt = 1'b0; s.rst = 1'b0; s.exp = e;
        s.chk = 1'b0; s.es = 0; s.ef = 0;
        return s;
    endfunction

    function automatic step_t lu8(input logic [8:0] e);
        step_t s;
        s = idle(e);
        s.ex_ren = 1'b1; s.ex_dest = 5'd8; s.rs = 5'd8;
        return s;
    endfunction

    function automatic step_t dmiss(input logic [8:0] e);
        step_t s;
        s = idle(e);
        s.dren = 1'b1;
        return s;
    endfunction

    task automatic drive(input step_t s);
        rst              = s.rst;
        bus.id_rs        = s.rs;
        bus.id_rt        = s.rt;
        bus.id_uses_rt   = s.uses_rt;
        bus.ex_memREN    = s.ex_ren;
        bus.ex_dest      = s.ex_dest;
        bus.mem_dmemREN  = s.dren;
        bus.mem_dmemWEN  = s.dwen;
        bus.dhit         = s.dhit;
        bus.ihit         = s.ihit;
        bus.mem_redirect = s.redir;
        bus.mem_halt     = s.halt;
    endtask

    function automatic logic [8:0] outs();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.halted};
    endfunction

    task automatic test_reset();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        st = idle(E_OFF); st.rst = 1'b1; s.push_back(st);
        st = lu8(E_OFF);  st.rst = 1'b1; st.redir = 1'b1; s.push_back(st);
        s.push_back(idle(E_BASE));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL reset_%0d got=%b want=%b", i, outs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        s.push_back(lu8(E_LU));
        s.push_back(lu8(E_BASE));          // bubble cycle: no repeat stall
        s.push_back(idle(E_BASE));
        st = idle(E_LU); st.ex_ren = 1'b1; st.ex_dest = 5'd9; st.rt = 5'd9; st.uses_rt = 1'b1;
        s.push_back(st);
        s.push_back(idle(E_BASE));
        st = lu8(E_LU); st.ihit = 1'b0; s.push_back(st);      // load-use beats ihit wait
        st = idle(E_IMISS); st.ihit = 1'b0; s.push_back(st);  // ihit wait still applies in bubble
        s.push_back(idle(E_BASE));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL load_use_%0d got=%b want=%b", i, outs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_stall();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        st = idle(E_BASE); st.ex_ren = 1'b1; st.ex_dest = 5'd0; st.rs = 5'd0; s.push_back(st);
        st = idle(E_BASE); st.ex_ren = 1'b1; st.ex_dest = 5'd9; st.rt = 5'd9; s.push_back(st);
        st = idle(E_BASE); st.ex_dest = 5'd8; st.rs = 5'd8; s.push_back(st);
        st = idle(E_BASE); st.dhit = 1'b1; s.push_back(st);   // stray dhit
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL no_stall_%0d got=%b want=%b", i, outs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dwait();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        for (int k = 0; k < 3; k++) s.push_back(dmiss(E_OFF));
        st = dmiss(E_BASE); st.dhit = 1'b1; s.push_back(st);
        s.push_back(idle(E_BASE));
        st = idle(E_OFF); st.dwen = 1'b1; s.push_back(st);
        st = idle(E_REDIR); st.dwen = 1'b1; st.dhit = 1'b1; st.redir = 1'b1; s.push_back(st);
        s.push_back(dmiss(E_OFF));
        st = lu8(E_LU); st.dren = 1'b1; st.dhit = 1'b1; s.push_back(st);
        s.push_back(lu8(E_BASE));
        s.push_back(dmiss(E_OFF));
        st = dmiss(E_OFF); st.rst = 1'b1; s.push_back(st);
        s.push_back(idle(E_BASE));         // no residual stall after reset in DWAIT
        s.push_back(lu8(E_LU));
        st = lu8(E_OFF); st.rst = 1'b1; s.push_back(st);
        s.push_back(lu8(E_LU));            // reset cleared the bubble state
        s.push_back(idle(E_BASE));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL dwait_%0d got=%b want=%b", i, outs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        st = lu8(E_REDIR); st.redir = 1'b1; st.ihit = 1'b0; s.push_back(st);
        s.push_back(lu8(E_LU));            // still in RUN, so load-use fires now
        s.push_back(idle(E_BASE));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL redirect_%0d got=%b want=%b", i, outs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        s.push_back(lu8(E_LU));
        st = lu8(E_OFF); st.dren = 1'b1; s.push_back(st);
        st = lu8(E_LU);  st.dren = 1'b1; st.dhit = 1'b1; s.push_back(st);
        s.push_back(lu8(E_BASE));
        s.push_back(idle(E_BASE));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL back_to_back_%0d got=%b want=%b", i, outs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        st = idle(E_OFF); st.halt = 1'b1; st.dwen = 1'b1; s.push_back(st);
        for (int k = 0; k < 10; k++) begin
            st = idle(E_HALTED);
            if (k == 3) st.redir = 1'b1;
            if (k == 6) st.dren = 1'b1;
            s.push_back(st);
        end
        st = idle(E_OFF); st.rst = 1'b1; s.push_back(st);
        s.push_back(idle(E_BASE));
        st = lu8(E_OFF); st.halt = 1'b1; st.redir = 1'b1; st.ihit = 1'b0; s.push_back(st);
        s.push_back(idle(E_HALTED));
        st = idle(E_OFF); st.rst = 1'b1; s.push_back(st);
        s.push_back(idle(E_BASE));
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL halt_%0d got=%b want=%b", i, outs(), e);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        step_t s[$];
        step_t st;
        logic [8:0] e;
        st = idle(E_OFF); st.rst = 1'b1; s.push_back(st);
        st = idle(E_BASE); st.chk = 1'b1; st.es = 0; st.ef = 0; s.push_back(st);
        s.push_back(lu8(E_LU));
        s.push_back(idle(E_BASE));
        for (int k = 0; k < 3; k++) s.push_back(dmiss(E_OFF));
        st = dmiss(E_BASE); st.dhit = 1'b1; s.push_back(st);
        st = idle(E_BASE); st.chk = 1'b1; st.es = 4; st.ef = 0; s.push_back(st);
        st = idle(E_REDIR); st.redir = 1'b1; s.push_back(st);
        st = idle(E_BASE); st.chk = 1'b1; st.es = 4; st.ef = 1; s.push_back(st);
        s.push_back(dmiss(E_OFF));
        st = dmiss(E_OFF); st.rst = 1'b1; st.chk = 1'b1; st.es = 5; st.ef = 1; s.push_back(st);
        st = idle(E_BASE); st.chk = 1'b1; st.es = 0; st.ef = 0; s.push_back(st);
        foreach (s[i]) begin
            drive(s[i]);
            exp_q.push_back(s[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (outs() !== e) begin
                bad++;
                $display("FAIL perf_ctl_%0d got=%b want=%b", i, outs(), e);
            end
            if (s[i].chk) begin
                total++;
                if (bus.stall_cycles !== CNT_W'(s[i].es)) begin
                    bad++;
                    $display("FAIL perf_stall_%0d got=%0d want=%0d", i, bus.stall_cycles, s[i].es);
                end
                total++;
                if (bus.flush_events !== CNT_W'(s[i].ef)) begin
                    bad++;
                    $display("FAIL perf_flush_%0d got=%0d want=%0d", i, bus.flush_events, s[i].ef);
                end
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_dwait();
        test_redirect();
        test_back_to_back();
        test_halt();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
